// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: selector codes, aluop/func
// encodings, FSM states and the pure decode function.
package alu_pkg;

  localparam logic [3:0] OPS_AND = 4'b0000;
  localparam logic [3:0] OPS_OR  = 4'b0001;
  localparam logic [3:0] OPS_ADD = 4'b0010;
  localparam logic [3:0] OPS_MOD = 4'b0011;
  localparam logic [3:0] OPS_NOR = 4'b0100;
  localparam logic [3:0] OPS_MUL = 4'b0101;
  localparam logic [3:0] OPS_SUB = 4'b0110;
  localparam logic [3:0] OPS_XOR = 4'b0111;
  localparam logic [3:0] OPS_DIV = 4'b1000;
  localparam logic [3:0] OPS_SLT = 4'b1001;
  localparam logic [3:0] OPS_LUI = 4'b1011;
  localparam logic [3:0] OPS_SRA = 4'b1100;
  localparam logic [3:0] OPS_SRL = 4'b1101;
  localparam logic [3:0] OPS_SLL = 4'b1110;
  localparam logic [3:0] OPS_NOP = 4'b1111;

  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
  localparam logic [3:0] ALUOP_LUI   = 4'b0011;
  localparam logic [3:0] ALUOP_AND   = 4'b0100;
  localparam logic [3:0] ALUOP_OR    = 4'b0101;
  localparam logic [3:0] ALUOP_SLT   = 4'b0110;
  localparam logic [3:0] ALUOP_XOR   = 4'b0111;
  localparam logic [3:0] ALUOP_NOP   = 4'b1000;
  localparam logic [3:0] ALUOP_SLL   = 4'b1001;
  localparam logic [3:0] ALUOP_SRL   = 4'b1011;
  localparam logic [3:0] ALUOP_SRA   = 4'b1111;

  localparam logic [5:0] FUNC_NOP  = 6'b000000;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_SLTU = 6'b101011;
  localparam logic [5:0] FUNC_MUL  = 6'b000010;
  localparam logic [5:0] FUNC_DIV  = 6'b011010;
  localparam logic [5:0] FUNC_MOD  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    K_SINGLE = 2'b00,
    K_MUL    = 2'b01,
    K_DIV    = 2'b10,
    K_MOD    = 2'b11
  } md_kind_e;

  typedef struct packed {
    logic [3:0] ops;
    logic       illegal;
    md_kind_e   kind;
  } decode_t;

  // With the engine disabled, mul/div/mod fall through to the illegal NOP code.
  function automatic decode_t aluDecode(input logic [3:0] aluop, input logic [5:0] func,
                                        input logic enMulDiv);
    decode_t d;
    d.ops     = OPS_NOP;
    d.illegal = 1'b0;
    d.kind    = K_SINGLE;
    case (aluop)
      ALUOP_ADD: d.ops = OPS_ADD;
      ALUOP_SUB: d.ops = OPS_SUB;
      ALUOP_LUI: d.ops = OPS_LUI;
      ALUOP_AND: d.ops = OPS_AND;
      ALUOP_OR:  d.ops = OPS_OR;
      ALUOP_SLT: d.ops = OPS_SLT;
      ALUOP_XOR: d.ops = OPS_XOR;
      ALUOP_NOP: d.ops = OPS_NOP;
      ALUOP_SLL: d.ops = OPS_SLL;
      ALUOP_SRL: d.ops = OPS_SRL;
      ALUOP_SRA: d.ops = OPS_SRA;
      ALUOP_RTYPE: begin
        case (func)
          FUNC_NOP:              d.ops = OPS_NOP;
          FUNC_AND:              d.ops = OPS_AND;
          FUNC_OR:               d.ops = OPS_OR;
          FUNC_ADD, FUNC_ADDU:   d.ops = OPS_ADD;
          FUNC_NOR:              d.ops = OPS_NOR;
          FUNC_SUB, FUNC_SUBU:   d.ops = OPS_SUB;
          FUNC_SLT, FUNC_SLTU:   d.ops = OPS_SLT;
          FUNC_MUL: begin
            if (enMulDiv) begin
              d.ops  = OPS_MUL;
              d.kind = K_MUL;
            end else begin
              d.illegal = 1'b1;
            end
          end
          FUNC_DIV: begin
            if (enMulDiv) begin
              d.ops  = OPS_DIV;
              d.kind = K_DIV;
            end else begin
              d.illegal = 1'b1;
            end
          end
          FUNC_MOD: begin
            if (enMulDiv) begin
              d.ops  = OPS_MOD;
              d.kind = K_MOD;
            end else begin
              d.illegal = 1'b1;
            end
          end
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide datapath.
// One step per cycle; result_o shows the value after the current step.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  md_kind_e         mode_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  // accQ: product accumulator (mul) or partial remainder (div).
  // aQ: shifting multiplicand or fixed divisor; bQ: multiplier or dividend/quotient.
  logic [WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0] aQ, aD;
  logic [WIDTH-1:0] bQ, bD;
  logic [CW-1:0]    cntQ;
  md_kind_e         modeQ;

  logic [WIDTH-1:0] mulAcc;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    mulAcc   = accQ + (bQ[0] ? aQ : '0);
    remShift = {accQ, bQ[WIDTH-1]};
    diff     = remShift - {1'b0, aQ};
    fits     = ~diff[WIDTH];
    accD     = accQ;
    aD       = aQ;
    bD       = bQ;
    if (modeQ == K_MUL) begin
      accD = mulAcc;
      aD   = aQ << 1;
      bD   = bQ >> 1;
    end else begin
      accD = fits ? diff[WIDTH-1:0] : remShift[WIDTH-1:0];
      bD   = {bQ[WIDTH-2:0], fits};
    end
  end

  always_comb begin
    result_o = accD;
    case (modeQ)
      K_MUL:   result_o = accD;
      K_DIV:   result_o = bD;
      default: result_o = accD;
    endcase
  end

  assign done_o = (cntQ == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      accQ  <= '0;
      aQ    <= '0;
      bQ    <= '0;
      cntQ  <= '0;
      modeQ <= K_MUL;
    end else if (start_i) begin
      accQ  <= '0;
      modeQ <= mode_i;
      cntQ  <= CW'(WIDTH - 1);
      if (mode_i == K_MUL) begin
        aQ <= opa_i;
        bQ <= opb_i;
      end else begin
        aQ <= opb_i;
        bQ <= opa_i;
      end
    end else if (step_i) begin
      accQ <= accD;
      aQ   <= aD;
      bQ   <= bD;
      if (cntQ != '0) cntQ <= cntQ - 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control: decodes aluop/func into the ALU selector and
// sequences multi-cycle mul/div/mod through the iterative engine.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EN_MULDIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       aluop_i,
  input  logic [5:0]       func_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [3:0]       ops_o,
  output logic             ops_valid_o,
  output logic             md_busy_o,
  output logic             md_done_o,
  output logic [WIDTH-1:0] md_result_o,
  output logic             div_by_zero_o,
  output logic             illegal_o
);

  state_e           stateQ;
  logic [3:0]       opsQ;
  logic             opsValidQ;
  logic             illegalQ;
  logic             mdDoneQ;
  logic [WIDTH-1:0] mdResultQ;
  logic             divByZeroQ;

  decode_t          dec;
  logic             accept;
  logic             divZero;
  logic             engStart;
  logic             engStep;
  logic             engDone;
  logic [WIDTH-1:0] engResult;

  always_comb begin
    dec      = aluDecode(aluop_i, func_i, EN_MULDIV != 0);
    accept   = req_valid_i && (stateQ == S_IDLE);
    divZero  = (dec.kind inside {K_DIV, K_MOD}) && (opb_i == '0);
    engStart = accept && (dec.kind != K_SINGLE) && !divZero;
    engStep  = (stateQ == S_MUL) || (stateQ == S_DIV);
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (engStart),
    .step_i   (engStep),
    .mode_i   (dec.kind),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .done_o   (engDone),
    .result_o (engResult)
  );

  // Pulses (ops_valid, md_done, div_by_zero) default low and are raised only
  // on the edge that produces them; ops/illegal change only on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ     <= S_IDLE;
      opsQ       <= OPS_NOP;
      opsValidQ  <= 1'b0;
      illegalQ   <= 1'b0;
      mdDoneQ    <= 1'b0;
      mdResultQ  <= '0;
      divByZeroQ <= 1'b0;
    end else begin
      opsValidQ  <= 1'b0;
      mdDoneQ    <= 1'b0;
      divByZeroQ <= 1'b0;
      case (stateQ)
        S_IDLE: begin
          if (accept) begin
            opsQ     <= dec.ops;
            illegalQ <= dec.illegal;
            case (dec.kind)
              K_SINGLE: opsValidQ <= 1'b1;
              K_MUL:    stateQ    <= S_MUL;
              default: begin
                if (divZero) begin
                  stateQ     <= S_DONE;
                  mdDoneQ    <= 1'b1;
                  divByZeroQ <= 1'b1;
                  mdResultQ  <= (dec.kind == K_DIV) ? '1 : opa_i;
                end else begin
                  stateQ <= S_DIV;
                end
              end
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (engDone) begin
            stateQ    <= S_DONE;
            mdDoneQ   <= 1'b1;
            mdResultQ <= engResult;
          end
        end
        default: stateQ <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (stateQ == S_IDLE);
  assign md_busy_o     = (stateQ == S_MUL) || (stateQ == S_DIV);
  assign ops_o         = opsQ;
  assign ops_valid_o   = opsValidQ;
  assign illegal_o     = illegalQ;
  assign md_done_o     = mdDoneQ;
  assign md_result_o   = mdResultQ;
  assign div_by_zero_o = divByZeroQ;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq at WIDTH=8: the driver pushes hand-computed
// expectations on accept, a negedge monitor pops them when the DUT responds.
module tb_alu_ctrl_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         reqValid = 1'b0;
  logic         reqReady;
  logic [3:0]   aluop = '0;
  logic [5:0]   func = '0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic [3:0]   ops;
  logic         opsValid;
  logic         mdBusy;
  logic         mdDone;
  logic [W-1:0] mdResult;
  logic         divByZero;
  logic         illegal;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string      name;
    bit         isDone;
    logic [3:0] ops;
    logic       ill;
    logic [7:0] res;
    logic       dbz;
    int         cyc;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;

  alu_ctrl_seq #(.WIDTH(W), .EN_MULDIV(1)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (reqValid),
    .req_ready_o   (reqReady),
    .aluop_i       (aluop),
    .func_i        (func),
    .opa_i         (opa),
    .opb_i         (opb),
    .ops_o         (ops),
    .ops_valid_o   (opsValid),
    .md_busy_o     (mdBusy),
    .md_done_o     (mdDone),
    .md_result_o   (mdResult),
    .div_by_zero_o (divByZero),
    .illegal_o     (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Drives the request until accepted and pushes the expected response.
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [5:0] fn,
                               input logic [7:0] a, input logic [7:0] b, input bit isMulti,
                               input logic [3:0] expOps, input logic expIll,
                               input logic [7:0] expRes, input logic expDbz,
                               input int lat, output int acceptCyc);
    exp_t e;
    int   waited = 0;
    bit   got = 0;
    acceptCyc = -1;
    while (!got && waited < 100) begin
      @(negedge clk);
      aluop    = op;
      func     = fn;
      opa      = a;
      opb      = b;
      reqValid = 1'b1;
      if (reqReady) begin
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        e.name = name; e.isDone = isMulti; e.ops = expOps; e.ill = expIll;
        e.res = expRes; e.dbz = expDbz; e.cyc = acceptCyc + lat;
        sbQ.push_back(e);
        got = 1;
      end else begin
        waited++;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL %s.accept_timeout got=not_accepted want=accepted", name);
    end
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    reqValid = 1'b0;
    while ((sbQ.size() != 0 || !reqReady) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, ".idle_reached"}, 32'(n < 100), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && (opsValid || mdDone)) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_event got ops_valid=%0b md_done=%0b want none",
                 opsValid, mdDone);
      end else begin
        monE = sbQ.pop_front();
        checkOutput({monE.name, ".is_done"}, 32'(mdDone), 32'(monE.isDone));
        checkOutput({monE.name, ".ops"}, 32'(ops), 32'(monE.ops));
        checkOutput({monE.name, ".cycle"}, cyc, monE.cyc);
        if (monE.isDone) begin
          checkOutput({monE.name, ".result"}, 32'(mdResult), 32'(monE.res));
          checkOutput({monE.name, ".div_by_zero"}, 32'(divByZero), 32'(monE.dbz));
        end else begin
          checkOutput({monE.name, ".illegal"}, 32'(illegal), 32'(monE.ill));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c1, c2, busyCnt, mdBusyCnt;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.ops", 32'(ops), 32'hF);
    checkOutput("rst.ops_valid", 32'(opsValid), 32'd0);
    checkOutput("rst.md_done", 32'(mdDone), 32'd0);
    checkOutput("rst.req_ready", 32'(reqReady), 32'd1);
    checkOutput("rst.md_busy", 32'(mdBusy), 32'd0);
    checkOutput("rst.md_result", 32'(mdResult), 32'd0);
    rst = 1'b0;

    $display("[TB] single-cycle decode");
    applyStimulus("add_r",   4'b0010, 6'b100000, 8'd0, 8'd0, 0, 4'b0010, 1'b0, 8'd0, 1'b0, 0, c1);
    applyStimulus("bad_op",  4'b1100, 6'b000000, 8'd0, 8'd0, 0, 4'b1111, 1'b1, 8'd0, 1'b0, 0, c1);
    applyStimulus("lw_add",  4'b0000, 6'b111111, 8'd0, 8'd0, 0, 4'b0010, 1'b0, 8'd0, 1'b0, 0, c1);
    applyStimulus("sra",     4'b1111, 6'b000000, 8'd0, 8'd0, 0, 4'b1100, 1'b0, 8'd0, 1'b0, 0, c1);
    applyStimulus("nop_r",   4'b0010, 6'b000000, 8'd0, 8'd0, 0, 4'b1111, 1'b0, 8'd0, 1'b0, 0, c1);
    applyStimulus("sltu_r",  4'b0010, 6'b101011, 8'd0, 8'd0, 0, 4'b1001, 1'b0, 8'd0, 1'b0, 0, c1);
    applyStimulus("bad_fn",  4'b0010, 6'b111111, 8'd0, 8'd0, 0, 4'b1111, 1'b1, 8'd0, 1'b0, 0, c1);
    applyStimulus("nor_r",   4'b0010, 6'b100111, 8'd0, 8'd0, 0, 4'b0100, 1'b0, 8'd0, 1'b0, 0, c1);
    waitIdle("single");

    $display("[TB] multiply");
    applyStimulus("mul13x11", 4'b0010, 6'b000010, 8'd13, 8'd11, 1, 4'b0101, 1'b0, 8'h8F, 1'b0, W, c1);
    reqValid  = 1'b0;
    busyCnt   = 0;
    mdBusyCnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (reqReady) break;
      busyCnt++;
      if (mdBusy) mdBusyCnt++;
    end
    checkOutput("mul.ready_low_cycles", busyCnt, 9);
    checkOutput("mul.busy_cycles", mdBusyCnt, 8);
    applyStimulus("mul200x3", 4'b0010, 6'b000010, 8'd200, 8'd3, 1, 4'b0101, 1'b0, 8'h58, 1'b0, W, c1);
    waitIdle("mul");

    $display("[TB] divide and modulo");
    applyStimulus("div100_7", 4'b0010, 6'b011010, 8'd100, 8'd7, 1, 4'b1000, 1'b0, 8'd14, 1'b0, W, c1);
    applyStimulus("mod100_7", 4'b0010, 6'b011011, 8'd100, 8'd7, 1, 4'b0011, 1'b0, 8'd2, 1'b0, W, c1);
    applyStimulus("div255_1", 4'b0010, 6'b011010, 8'd255, 8'd1, 1, 4'b1000, 1'b0, 8'd255, 1'b0, W, c1);
    applyStimulus("mod7_9",   4'b0010, 6'b011011, 8'd7, 8'd9, 1, 4'b0011, 1'b0, 8'd7, 1'b0, W, c1);
    waitIdle("div");

    $display("[TB] divide by zero");
    applyStimulus("div5_0", 4'b0010, 6'b011010, 8'd5, 8'd0, 1, 4'b1000, 1'b0, 8'hFF, 1'b1, 0, c1);
    applyStimulus("mod5_0", 4'b0010, 6'b011011, 8'd5, 8'd0, 1, 4'b0011, 1'b0, 8'd5, 1'b1, 0, c2);
    checkOutput("dbz.reaccept_gap", c2 - c1, 2);
    waitIdle("dbz");

    $display("[TB] reset during divide");
    applyStimulus("div_rst", 4'b0010, 6'b011010, 8'd200, 8'd9, 1, 4'b1000, 1'b0, 8'd22, 1'b0, W, c1);
    reqValid = 1'b0;
    repeat (4) @(negedge clk);
    sbQ.delete();
    rst = 1'b1;
    #1;
    checkOutput("midrst.ops", 32'(ops), 32'hF);
    checkOutput("midrst.req_ready", 32'(reqReady), 32'd1);
    checkOutput("midrst.md_busy", 32'(mdBusy), 32'd0);
    checkOutput("midrst.md_done", 32'(mdDone), 32'd0);
    checkOutput("midrst.md_result", 32'(mdResult), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus("div_after_rst", 4'b0010, 6'b011010, 8'd100, 8'd7, 1, 4'b1000, 1'b0, 8'd14, 1'b0, W, c1);
    waitIdle("midrst");

    $display("[TB] back-to-back with held request");
    applyStimulus("b2b_mul1", 4'b0010, 6'b000010, 8'd13, 8'd11, 1, 4'b0101, 1'b0, 8'h8F, 1'b0, W, c1);
    applyStimulus("b2b_mul2", 4'b0010, 6'b000010, 8'd7, 8'd9, 1, 4'b0101, 1'b0, 8'd63, 1'b0, W, c2);
    reqValid = 1'b0;
    checkOutput("b2b.accept_gap", c2 - c1, W + 2);
    waitIdle("b2b");
    repeat (5) @(negedge clk);
    checkOutput("end.queue_empty", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
